// File: rtl/apb_result_pkg.sv
// Shared register map, STATUS/CTRL bit positions and the STATUS layout for apb_result_buffer.
package apb_result_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_TSTAMP = 2'd3;

  localparam int ST_COUNT_LSB = 0;
  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVF_BIT   = 10;
  localparam int ST_DROP_LSB  = 16;
  localparam int ST_DEPTH_LSB = 24;

  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLR_BIT   = 1;

  typedef struct packed {
    logic [7:0] depth;
    logic [7:0] drop_cnt;
    logic [4:0] rsvd;
    logic       overflow;
    logic       full;
    logic       empty;
    logic [7:0] count;
  } status_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Generic synchronous FIFO: push/pop/flush, count-derived full/empty, also exposes next count.
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (flush) count_next = '0;
    else       count_next = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_result_buffer.sv
// APB3 result buffer: captures datao/valido into a FIFO, exposes DATA/STATUS/CTRL and a threshold irq.
// Optional RESULT_TIMESTAMP_EN adds a cycle counter, per-entry timestamps and the TSTAMP register.
module apb_result_buffer
  import apb_result_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DW     = 32,
  parameter int THRESH = 4
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic [DW-1:0] datao,
  input  logic          valido,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [3:0]    paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr,
  output logic          irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    idx;
  logic          access;
  logic          pop;
  logic          flush;
  logic          clr;
  logic          ovf_event;
  logic [DW-1:0] fifo_dout;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic [31:0]   status_word;
  status_t       status;
  logic          unused_bits;

  assign pready = 1'b1;
  assign idx    = paddr[3:2];
  // Reset aborts any transfer in flight.
  assign access = psel & penable & ~preset;
  assign pop    = access & ~pwrite & (idx == ADDR_DATA) & ~empty;
  assign flush  = access & pwrite & (idx == ADDR_CTRL) & pwdata[CTRL_FLUSH_BIT];
  assign clr    = access & pwrite & (idx == ADDR_CTRL) & pwdata[CTRL_CLR_BIT];
  // A flush swallows the incoming word silently, so it is never a drop.
  assign ovf_event = valido & full & ~pop & ~flush;

  assign unused_bits = ^{paddr[1:0], pwdata[DW-1:2]};

  result_fifo #(.DEPTH(DEPTH), .DW(DW)) u_data_fifo (
    .clk        (pclk),
    .rst        (preset),
    .push       (valido),
    .pop        (pop),
    .flush      (flush),
    .din        (datao),
    .dout       (fifo_dout),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

`ifdef RESULT_TIMESTAMP_EN
  logic [31:0]   ts_cnt;
  logic [31:0]   tstamp;
  logic [31:0]   ts_dout;
  logic [CW-1:0] ts_unused_count;
  logic [CW-1:0] ts_unused_count_next;
  logic          ts_unused_full;
  logic          ts_unused_empty;

  // Runs in lockstep with the data FIFO: same push/pop/flush, so the heads always pair up.
  result_fifo #(.DEPTH(DEPTH), .DW(32)) u_ts_fifo (
    .clk        (pclk),
    .rst        (preset),
    .push       (valido),
    .pop        (pop),
    .flush      (flush),
    .din        (ts_cnt),
    .dout       (ts_dout),
    .count      (ts_unused_count),
    .count_next (ts_unused_count_next),
    .full       (ts_unused_full),
    .empty      (ts_unused_empty)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      ts_cnt <= '0;
      tstamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (pop) tstamp <= ts_dout;
    end
  end
`endif

  always_comb begin
    status_word = '0;
    status_word[ST_COUNT_LSB +: 8] = 8'(count);
    status_word[ST_EMPTY_BIT]      = empty;
    status_word[ST_FULL_BIT]       = full;
    status_word[ST_OVF_BIT]        = overflow;
    status_word[ST_DROP_LSB +: 8]  = drop_cnt;
    status_word[ST_DEPTH_LSB +: 8] = 8'(DEPTH);
  end

  assign status = status_t'(status_word);

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (access) begin
      case (idx)
        ADDR_DATA: begin
          if (pwrite || empty) pslverr = 1'b1;
          else                 prdata  = fifo_dout;
        end
        ADDR_STATUS: begin
          if (pwrite) pslverr = 1'b1;
          else        prdata  = DW'(status);
        end
        ADDR_CTRL: begin
          prdata = '0;
        end
        ADDR_TSTAMP: begin
`ifdef RESULT_TIMESTAMP_EN
          if (pwrite) pslverr = 1'b1;
          else        prdata  = DW'(tstamp);
`else
          pslverr = 1'b1;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
      irq      <= 1'b0;
    end else begin
      irq <= (count_next >= CW'(THRESH));
      // A drop in the same cycle as a clear wins and restarts the count at one.
      if (ovf_event) begin
        overflow <= 1'b1;
        drop_cnt <= clr ? 8'd1 : sat_inc8(drop_cnt);
      end else if (clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/apb_result_buffer.md
Name: apb_result_buffer

Overview:
- Downstream consumer of the compute datapath's result stream (`datao`/`valido`).
- Captures each valid 32-bit result into an internal FIFO.
- Exposes the results to software through an APB3 slave port: data pop, status, control, and a threshold interrupt.
- Decouples the compute burst from slow APB polling by the CPU.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DW, 32, result/data width; also the APB data width.
- THRESH, 4, occupancy at which irq asserts; range 1..DEPTH.

Ports:
- pclk  in  1  single clock, rising-edge.
- preset  in  1  reset; synchronous, active-high.
- datao  in  DW  result word from the compute stage.
- valido  in  1  datao is valid this cycle; 1-cycle strobe, no backpressure.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB write.
- paddr  in  4  byte address; bits [3:2] decoded.
- pwdata  in  DW  APB write data.
- prdata  out  DW  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- irq  out  1  FIFO count >= THRESH, registered.

Behaviour:
- Reset (preset=1 at a pclk edge):
  - count=0, rd/wr pointers=0, overflow=0, drop_cnt=0.
  - prdata=0, pslverr=0, irq=0; pready=1 as a constant.
  - FIFO storage is not cleared.
  - A reset mid-APB-transfer aborts the transfer; the master must restart it.
- Push: on valido=1, if count<DEPTH, datao is written at wr_ptr, wr_ptr increments mod DEPTH, and count increments.
- Overflow: valido=1 with count==DEPTH and no pop in the same cycle:
  - word is dropped;
  - overflow sticky is set to 1;
  - drop_cnt (8-bit) increments, saturating at 255.
- APB protocol: zero wait states; pready=1 always. The transfer completes in the access cycle (psel & penable).
- Register map (offsets):
  - 0x0 DATA, RO:
    - Read returns the FIFO head and pops it: rd_ptr++, count-- at the end of the access cycle.
    - Read when empty: prdata=0, pslverr=1, no pop.
  - 0x4 STATUS, RO:
    - [7:0] count, [8] empty, [9] full, [10] overflow;
    - [23:16] drop_cnt, [31:24] DEPTH.
  - 0x8 CTRL, WO:
    - bit0=1 flushes: pointers=0, count=0.
    - bit1=1 clears overflow and drop_cnt.
    - Reads return 0 with no error.
  - 0xC TSTAMP: see Optional Feature; otherwise reserved.
  - Writes to DATA or STATUS, and any access to a reserved offset: pslverr=1, no side effects.
- Read data timing: prdata and pslverr are combinational during the access phase and 0 outside it.
- Simultaneous push and pop: both occur; count is unchanged. This applies when full too, so the push is accepted and no overflow occurs.
- Simultaneous push and flush: flush wins; the pushed word is discarded and is not counted as a drop.
- Simultaneous overflow event and overflow-clear: the set wins; overflow=1 and drop_cnt=1.
- Pointer wrap: pointers are log2(DEPTH) bits wide, so wrap is natural; full and empty are taken from count.
- irq: registered as irq <= (next count >= THRESH), so it is valid 1 cycle after the push or pop that crosses the threshold.

Optional Feature:
- Macro: RESULT_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter runs, reset to 0 and wrapping at 2^32.
  - Each pushed word stores the counter value from its push cycle in a parallel FIFO.
  - A DATA pop latches that entry's timestamp into a TSTAMP holding register, readable at 0xC without error.
  - Flush does not clear TSTAMP.
- Not defined:
  - No counter and no parallel storage exist.
  - 0xC is reserved (pslverr=1).
  - Area is reduced accordingly.

Decomposition:
- Package apb_result_pkg:
  - register offset constants (ADDR_DATA, ADDR_STATUS, ADDR_CTRL, ADDR_TSTAMP);
  - STATUS bit-position constants;
  - CTRL bit constants;
  - a status_t packed struct.
- Sub-module result_fifo:
  - generic synchronous FIFO with push, pop, flush, dout, count, full, empty;
  - parameterised DEPTH/DW;
  - instantiated twice when RESULT_TIMESTAMP_EN is defined.
- The top level holds the APB decode, the sticky/drop logic, and irq.

Test Plan:
- Reset, then read STATUS -> prdata=0x0800_0100 (DEPTH=8, empty=1); read DATA -> prdata=0, pslverr=1.
- Push 23,24,25 (valido strobes), then read DATA 3 times -> 23, 24, 25 in order; the 4th read gives pslverr=1; irq stays 0.
- Push 4 words -> irq=1 one cycle after the 4th push; one DATA read -> irq=0 one cycle later.
- Push 10 words without reads -> STATUS shows count=8, full=1, overflow=1, drop_cnt=2; the DATA reads return the first 8 words. Then write CTRL=0x2 -> overflow=0, drop_cnt=0.
- With FIFO full, a DATA read and valido in the same cycle -> count stays 8, overflow stays 0, and the new word appears as the 8th readout.
- Write CTRL=0x1 in the same cycle as valido with data 0x55 -> count=0, and 0x55 is never read back. With RESULT_TIMESTAMP_EN defined: push at cycle N, then a DATA read followed by a TSTAMP read -> TSTAMP returns N.
